// File: rtl/axi_pkg.sv
// Shared AXI encodings and the read responder state type.
package axi_pkg;

  localparam logic [1:0] BURST_FIXED = 2'd0;
  localparam logic [1:0] BURST_INCR  = 2'd1;
  localparam logic [1:0] BURST_WRAP  = 2'd2;

  localparam logic [1:0] RESP_OKAY   = 2'd0;
  localparam logic [1:0] RESP_SLVERR = 2'd2;
  localparam logic [1:0] RESP_DECERR = 2'd3;

  typedef enum logic [2:0] {IDLE, WAIT, READ, FILL, RESP} rd_state_t;

endpackage

// File: rtl/axi_burst_read_responder_if.sv
// AXI4 read address / read data channel bundle.
interface axi_burst_read_responder_if;
  logic        arvalid;
  logic        arready;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic        rvalid;
  logic        rready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;

  modport slave (
    input  arvalid, araddr, arlen, arsize, arburst, rready,
    output arready, rvalid, rdata, rresp, rlast
  );

  modport master (
    output arvalid, araddr, arlen, arsize, arburst, rready,
    input  arready, rvalid, rdata, rresp, rlast
  );
endinterface

// File: rtl/axi_burst_addr_gen.sv
// Next beat address for FIXED / INCR / WRAP bursts (shared with the write side).
module axi_burst_addr_gen
  import axi_pkg::*;
(
  input  logic [31:0] cur_addr,
  input  logic [31:0] start,
  input  logic [7:0]  len,
  input  logic [2:0]  size,
  input  logic [1:0]  burst,
  output logic [31:0] next_addr
);

  logic [31:0] bytes;
  logic [31:0] span;
  logic [31:0] lower;
  logic [31:0] incr;

  // Step by one beat; WRAP folds back to the aligned line base at the span boundary.
  always_comb begin
    bytes     = 32'd1 << size;
    span      = bytes * ({24'd0, len} + 32'd1);
    lower     = start & ~(span - 32'd1);
    incr      = cur_addr + bytes;
    next_addr = incr;
    case (burst)
      BURST_FIXED: next_addr = cur_addr;
      BURST_WRAP:  if (incr == lower + span) next_addr = lower;
      default:     next_addr = incr;
    endcase
  end

endmodule

// File: rtl/axi_burst_read_responder.sv
// AXI4 read responder over a synchronous word memory: one memory read per beat,
// three cycles per beat, errors fixed at AR time (SLVERR) or per beat (DECERR).
module axi_burst_read_responder
  import axi_pkg::*;
#(
  parameter logic [31:0] BASE      = 32'h8000_0000,
  parameter int          ADDR_BITS = 16,
  parameter int          FIRST_LAT = 2
) (
  input  logic                    clock,
  input  logic                    reset,
  axi_burst_read_responder_if.slave bus,
  output logic                    mem_en,
  output logic [ADDR_BITS-1:0]    mem_addr,
  input  logic [31:0]             mem_rdata
);

  rd_state_t            state_q, state_d;
  logic [3:0]           lat_q, lat_d;
  logic [7:0]           beat_q, beat_d;
  logic [7:0]           len_q, len_d;
  logic [2:0]           size_q, size_d;
  logic [1:0]           burst_q, burst_d;
  logic [31:0]          start_q, start_d;
  logic [31:0]          cur_addr_q, cur_addr_d;
  logic                 slverr_q, slverr_d;
  logic                 rvalid_q, rvalid_d;
  logic                 rlast_q, rlast_d;
  logic [1:0]           rresp_q, rresp_d;
  logic [31:0]          rdata_q, rdata_d;
  logic                 mem_en_q, mem_en_d;
  logic [ADDR_BITS-1:0] mem_addr_q, mem_addr_d;
  logic [31:0]          next_addr;

  function automatic logic in_range(input logic [31:0] addr);
    logic [31:0] off;
    off = addr - BASE;
    return (addr >= BASE) && ((off >> (ADDR_BITS + 2)) == 32'd0);
  endfunction

  function automatic logic [ADDR_BITS-1:0] word_idx(input logic [31:0] addr);
    logic [31:0] off;
    off = addr - BASE;
    return ADDR_BITS'(off >> 2);
  endfunction

  function automatic logic is_slverr(input logic [2:0] size, input logic [7:0] len,
                                     input logic [1:0] burst);
    logic bad_wrap;
    bad_wrap = (burst == BURST_WRAP) &&
               !(len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15);
    return (size > 3'd2) || (burst == 2'd3) || bad_wrap;
  endfunction

  axi_burst_addr_gen u_addr_gen (
    .cur_addr (cur_addr_q),
    .start    (start_q),
    .len      (len_q),
    .size     (size_q),
    .burst    (burst_q),
    .next_addr(next_addr)
  );

  assign bus.arready = !reset && (state_q == IDLE);
  assign bus.rvalid  = rvalid_q;
  assign bus.rdata   = rdata_q;
  assign bus.rresp   = rresp_q;
  assign bus.rlast   = rlast_q;
  assign mem_en      = mem_en_q;
  assign mem_addr    = mem_addr_q;

  // Next-state logic: burst FSM, latency and beat counters, memory strobe, R registers.
  always_comb begin
    state_d    = state_q;
    lat_d      = lat_q;
    beat_d     = beat_q;
    len_d      = len_q;
    size_d     = size_q;
    burst_d    = burst_q;
    start_d    = start_q;
    cur_addr_d = cur_addr_q;
    slverr_d   = slverr_q;
    rvalid_d   = rvalid_q;
    rlast_d    = rlast_q;
    rresp_d    = rresp_q;
    rdata_d    = rdata_q;
    mem_en_d   = 1'b0;
    mem_addr_d = mem_addr_q;
    case (state_q)
      IDLE: begin
        if (bus.arvalid) begin
          start_d    = bus.araddr;
          cur_addr_d = bus.araddr;
          len_d      = bus.arlen;
          size_d     = bus.arsize;
          burst_d    = bus.arburst;
          slverr_d   = is_slverr(bus.arsize, bus.arlen, bus.arburst);
          beat_d     = 8'd0;
          lat_d      = 4'(FIRST_LAT);
          if (FIRST_LAT == 0) begin
            state_d    = READ;
            mem_en_d   = !slverr_d && in_range(bus.araddr);
            mem_addr_d = word_idx(bus.araddr);
          end else begin
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        lat_d = lat_q - 4'd1;
        if (lat_d == 4'd0) begin
          state_d    = READ;
          mem_en_d   = !slverr_q && in_range(cur_addr_q);
          mem_addr_d = word_idx(cur_addr_q);
        end
      end
      READ: state_d = FILL;
      FILL: begin
        rvalid_d = 1'b1;
        rlast_d  = (beat_q == len_q);
        if (slverr_q) begin
          rresp_d = RESP_SLVERR;
          rdata_d = 32'd0;
        end else if (!in_range(cur_addr_q)) begin
          rresp_d = RESP_DECERR;
          rdata_d = 32'd0;
        end else begin
          rresp_d = RESP_OKAY;
          rdata_d = mem_rdata;
        end
        state_d = RESP;
      end
      RESP: begin
        if (bus.rready) begin
          rvalid_d = 1'b0;
          if (rlast_q) begin
            rlast_d = 1'b0;
            state_d = IDLE;
          end else begin
            cur_addr_d = next_addr;
            beat_d     = beat_q + 8'd1;
            state_d    = READ;
            mem_en_d   = !slverr_q && in_range(next_addr);
            mem_addr_d = word_idx(next_addr);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers; reset abandons any burst in flight.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= IDLE;
      lat_q      <= 4'd0;
      beat_q     <= 8'd0;
      len_q      <= 8'd0;
      size_q     <= 3'd0;
      burst_q    <= 2'd0;
      start_q    <= 32'd0;
      cur_addr_q <= 32'd0;
      slverr_q   <= 1'b0;
      rvalid_q   <= 1'b0;
      rlast_q    <= 1'b0;
      rresp_q    <= 2'd0;
      rdata_q    <= 32'd0;
      mem_en_q   <= 1'b0;
      mem_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      lat_q      <= lat_d;
      beat_q     <= beat_d;
      len_q      <= len_d;
      size_q     <= size_d;
      burst_q    <= burst_d;
      start_q    <= start_d;
      cur_addr_q <= cur_addr_d;
      slverr_q   <= slverr_d;
      rvalid_q   <= rvalid_d;
      rlast_q    <= rlast_d;
      rresp_q    <= rresp_d;
      rdata_q    <= rdata_d;
      mem_en_q   <= mem_en_d;
      mem_addr_q <= mem_addr_d;
    end
  end

endmodule

// File: tb/tb_axi_burst_read_responder.sv
// Directed bench for axi_burst_read_responder; memory word i holds 0xC0DE_0000 | i.
module tb_axi_burst_read_responder;
  import axi_pkg::*;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        mem_en;
  logic [15:0] mem_addr;
  logic [31:0] mem_rdata = 32'd0;
  int          vectors = 0;
  int          miscompares = 0;
  int          mem_en_cnt = 0;

  logic [31:0] d;
  logic [1:0]  r;
  logic        l;
  int          w;
  int          n;
  int          cyc;
  int          beat;
  int          busy;
  int          en_base;
  logic        held_valid;
  logic [31:0] held_data;
  logic [31:0] exp3 [4];

  axi_burst_read_responder_if bus ();

  axi_burst_read_responder #(
    .BASE     (32'h8000_0000),
    .ADDR_BITS(16),
    .FIRST_LAT(2)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .bus      (bus),
    .mem_en   (mem_en),
    .mem_addr (mem_addr),
    .mem_rdata(mem_rdata)
  );

  always #5 clock = ~clock;

  // Synchronous memory with a recognisable pattern, plus a read-strobe counter.
  always @(posedge clock) begin
    if (mem_en) begin
      mem_rdata  <= {16'hC0DE, mem_addr};
      mem_en_cnt <= mem_en_cnt + 1;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic send_ar(input logic [31:0] addr, input logic [7:0] len,
                         input logic [2:0] size, input logic [1:0] burst);
    int k;
    k = 0;
    bus.arvalid = 1'b1;
    bus.araddr  = addr;
    bus.arlen   = len;
    bus.arsize  = size;
    bus.arburst = burst;
    while (!bus.arready && k < 50) begin
      @(negedge clock);
      k++;
    end
    check("ar_timeout", 32'(k >= 50), 32'd0);
    @(posedge clock);
    @(negedge clock);
    bus.arvalid = 1'b0;
  endtask

  task automatic get_beat(output logic [31:0] od, output logic [1:0] orr,
                          output logic ol, output int waited);
    waited = 0;
    while (!(bus.rvalid && bus.rready) && waited < 100) begin
      @(negedge clock);
      waited++;
    end
    check("beat_timeout", 32'(waited >= 100), 32'd0);
    od  = bus.rdata;
    orr = bus.rresp;
    ol  = bus.rlast;
    @(negedge clock);
  endtask

  initial begin
    exp3[0] = 32'hC0DE_0002;
    exp3[1] = 32'hC0DE_0003;
    exp3[2] = 32'hC0DE_0000;
    exp3[3] = 32'hC0DE_0001;
    bus.arvalid = 1'b0;
    bus.araddr  = 32'd0;
    bus.arlen   = 8'd0;
    bus.arsize  = 3'd0;
    bus.arburst = 2'd0;
    bus.rready  = 1'b0;

    // Reset state
    @(negedge clock);
    @(negedge clock);
    check("rst_rvalid", 32'(bus.rvalid), 32'd0);
    check("rst_rlast", 32'(bus.rlast), 32'd0);
    check("rst_rresp", 32'(bus.rresp), 32'd0);
    check("rst_rdata", bus.rdata, 32'd0);
    check("rst_mem_en", 32'(mem_en), 32'd0);
    check("rst_arready_in_reset", 32'(bus.arready), 32'd0);
    reset = 1'b0;
    #1;
    check("rst_arready_after", 32'(bus.arready), 32'd1);

    // 1: INCR single beat
    bus.rready = 1'b1;
    send_ar(32'h8000_0010, 8'd0, 3'd2, BURST_INCR);
    check("t1_arready_busy", 32'(bus.arready), 32'd0);
    get_beat(d, r, l, w);
    check("t1_latency", 32'(w), 32'd4);
    check("t1_data", d, 32'hC0DE_0004);
    check("t1_resp", 32'(r), 32'd0);
    check("t1_last", 32'(l), 32'd1);
    check("t1_rvalid_drop", 32'(bus.rvalid), 32'd0);

    // 2: INCR 4 beats with rready toggling every cycle
    bus.rready = 1'b0;
    send_ar(32'h8000_0000, 8'd3, 3'd2, BURST_INCR);
    beat = 0;
    cyc = 0;
    held_valid = 1'b0;
    held_data = 32'd0;
    while (beat < 4 && cyc < 200) begin
      bus.rready = cyc[0];
      if (bus.rvalid) begin
        if (held_valid) check("t2_hold_data", bus.rdata, held_data);
        if (bus.rready) begin
          check("t2_data", bus.rdata, 32'hC0DE_0000 + 32'(beat));
          check("t2_last", 32'(bus.rlast), 32'(beat == 3));
          check("t2_resp", 32'(bus.rresp), 32'd0);
          beat++;
          held_valid = 1'b0;
        end else begin
          held_valid = 1'b1;
          held_data = bus.rdata;
        end
      end
      @(negedge clock);
      cyc++;
    end
    check("t2_beats", 32'(beat), 32'd4);
    bus.rready = 1'b1;

    // 3: WRAP 4 beats starting mid-line
    send_ar(32'h8000_0008, 8'd3, 3'd2, BURST_WRAP);
    for (int i = 0; i < 4; i++) begin
      get_beat(d, r, l, w);
      check("t3_data", d, exp3[i]);
      check("t3_resp", 32'(r), 32'd0);
      check("t3_last", 32'(l), 32'(i == 3));
    end

    // 4a: unsupported size -> SLVERR on every beat, no memory access
    en_base = mem_en_cnt;
    send_ar(32'h8000_0000, 8'd1, 3'd3, BURST_INCR);
    for (int i = 0; i < 2; i++) begin
      get_beat(d, r, l, w);
      check("t4a_resp", 32'(r), 32'd2);
      check("t4a_data", d, 32'd0);
      check("t4a_last", 32'(l), 32'(i == 1));
    end
    check("t4a_mem_en", 32'(mem_en_cnt - en_base), 32'd0);

    // 4b: address below BASE -> DECERR
    en_base = mem_en_cnt;
    send_ar(32'h7FFF_FFFC, 8'd0, 3'd2, BURST_INCR);
    get_beat(d, r, l, w);
    check("t4b_resp", 32'(r), 32'd3);
    check("t4b_data", d, 32'd0);
    check("t4b_last", 32'(l), 32'd1);
    check("t4b_mem_en", 32'(mem_en_cnt - en_base), 32'd0);

    // 5: reset during beat 2 of an 8-beat burst
    send_ar(32'h8000_0020, 8'd7, 3'd2, BURST_INCR);
    get_beat(d, r, l, w);
    check("t5_beat0", d, 32'hC0DE_0008);
    get_beat(d, r, l, w);
    check("t5_beat1", d, 32'hC0DE_0009);
    bus.rready = 1'b0;
    n = 0;
    while (!bus.rvalid && n < 50) begin
      @(negedge clock);
      n++;
    end
    check("t5_beat2_valid", 32'(bus.rvalid), 32'd1);
    reset = 1'b1;
    @(negedge clock);
    check("t5_rvalid_reset", 32'(bus.rvalid), 32'd0);
    reset = 1'b0;
    #1;
    check("t5_arready", 32'(bus.arready), 32'd1);
    check("t5_rdata", bus.rdata, 32'd0);
    bus.rready = 1'b1;
    busy = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      if (bus.rvalid) busy++;
    end
    check("t5_no_residual", 32'(busy), 32'd0);
    send_ar(32'h8000_0040, 8'd0, 3'd2, BURST_INCR);
    get_beat(d, r, l, w);
    check("t5_new_data", d, 32'hC0DE_0010);
    check("t5_new_last", 32'(l), 32'd1);

    // 6: arvalid held high across a burst
    bus.arvalid = 1'b1;
    bus.araddr  = 32'h8000_0000;
    bus.arlen   = 8'd1;
    bus.arsize  = 3'd2;
    bus.arburst = BURST_INCR;
    check("t6_arready_idle", 32'(bus.arready), 32'd1);
    @(posedge clock);
    @(negedge clock);
    bus.araddr = 32'h8000_0100;
    bus.arlen  = 8'd0;
    n = 0;
    busy = 0;
    beat = 0;
    while (beat < 2 && n < 100) begin
      if (bus.arready) busy++;
      if (bus.rvalid && bus.rready) begin
        check("t6_data", bus.rdata, 32'hC0DE_0000 + 32'(beat));
        check("t6_last", 32'(bus.rlast), 32'(beat == 1));
        beat++;
      end
      @(negedge clock);
      n++;
    end
    check("t6_arready_busy", 32'(busy), 32'd0);
    check("t6_arready_after_last", 32'(bus.arready), 32'd1);
    @(posedge clock);
    @(negedge clock);
    bus.arvalid = 1'b0;
    check("t6_second_accepted", 32'(bus.arready), 32'd0);
    get_beat(d, r, l, w);
    check("t6_second_latency", 32'(w), 32'd4);
    check("t6_second_data", d, 32'hC0DE_0040);
    check("t6_second_last", 32'(l), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
